// File: rtl/line_clear_pkg.sv
// Shared cell codes, default playfield geometry and sequencer state encoding
// for the completed-row handling block.
package line_clear_pkg;

    localparam int DEF_ROWS = 12;
    localparam int DEF_COLS = 10;

    localparam logic [3:0] EMPTY_CODE  = 4'h0;
    localparam logic [3:0] T_CODE      = 4'h1;
    localparam logic [3:0] SQUARE_CODE = 4'h2;
    localparam logic [3:0] J_CODE      = 4'h3;
    localparam logic [3:0] L_CODE      = 4'h4;
    localparam logic [3:0] Z_CODE      = 4'h5;
    localparam logic [3:0] S_CODE      = 4'h6;
    localparam logic [3:0] LINE_CODE   = 4'h7;
    localparam logic [3:0] CURSED_CODE = 4'h8;
    localparam logic [3:0] FLASH_CODE  = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLASH,
        COLLAPSE,
        DONE
    } state_t;

    // cell j occupies bits [4j +: 4]; cell 0 holds the most significant nibble
    typedef logic [0:4*DEF_COLS-1] row_t;

endpackage

// File: rtl/line_clear_ctrl_row_full_detect.sv
// Combinational full-row detector: a row is full when no cell holds the empty code.
module row_full_detect
    import line_clear_pkg::*;
#(
    parameter int COLS = DEF_COLS
) (
    input  logic [0:4*COLS-1] row,
    output logic              full
);

    always_comb begin
        full = 1'b1;
        for (int j = 0; j < COLS; j++) begin
            if (row[4*j +: 4] == EMPTY_CODE) full = 1'b0;
        end
    end

endmodule

// File: rtl/line_clear_ctrl.sv
// Completed-row sequencer: snapshot, scan, flash and collapse the playfield.
// Defining LINE_CLEAR_TOTAL_EN adds a saturating running total of cleared lines.
//
// state    | meaning
// IDLE     | pass board_in through (one cycle late), wait for start
// SCAN     | test one snapshot row per cycle, top to bottom, build full_mask
// FLASH    | blink masked rows with FLASH_CODE, one toggle per frame_tick
// COLLAPSE | bottom-up in-place compaction, then zero-fill the vacated top rows
// DONE     | one-cycle done pulse, board_out holds the compacted board
module line_clear_ctrl
    import line_clear_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int FLASH_FRAMES = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              frame_tick,
    input  logic [ROWS-1:0][0:4*COLS-1]       board_in,
    output logic [ROWS-1:0][0:4*COLS-1]       board_out,
    output logic                              busy,
    output logic                              done,
    output logic [$clog2(ROWS+1)-1:0]         lines_cleared
`ifdef LINE_CLEAR_TOTAL_EN
    ,
    output logic [15:0]                       total_lines
`endif
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int IW = RW + 1;
    localparam int LW = $clog2(ROWS + 1);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [IW-1:0] BOTTOM    = IW'(ROWS - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [FW-1:0] LAST_TICK = FW'(FLASH_FRAMES - 1);

    state_t state, state_nx;

    logic [ROWS-1:0][0:4*COLS-1] board_q;
    logic [ROWS-1:0][0:4*COLS-1] work;
    logic [ROWS-1:0]             full_mask;
    logic [ROWS-1:0]             mask_scan;
    logic [RW-1:0]               row_ptr;
    logic [IW-1:0]               rd;
    logic [IW-1:0]               wr;
    logic [RW-1:0]               rd_idx;
    logic [RW-1:0]               wr_idx;
    logic [FW-1:0]               tick_cnt;
    logic                        phase;
    logic [0:4*COLS-1]           scan_row;
    logic                        scan_full;
    logic                        scan_last;
    logic                        flash_end;
    logic                        collapse_end;
    logic [LW-1:0]               n_full;

    assign scan_row = work[row_ptr];

    row_full_detect #(
        .COLS (COLS)
    ) u_row_full_detect (
        .row  (scan_row),
        .full (scan_full)
    );

    assign rd_idx       = rd[RW-1:0];
    assign wr_idx       = wr[RW-1:0];
    assign scan_last    = (state == SCAN) && (row_ptr == LAST_ROW);
    assign flash_end    = (state == FLASH) && frame_tick && (tick_cnt == LAST_TICK);
    // rd has wrapped below row 0 once its top bit is set; wr==0 is the last zero-fill
    assign collapse_end = (state == COLLAPSE) && rd[RW] && (wr == '0);

    always_comb begin
        mask_scan = full_mask;
        if (scan_full) mask_scan[row_ptr] = 1'b1;
    end

    always_comb begin
        n_full = '0;
        for (int i = 0; i < ROWS; i++) begin
            n_full = n_full + LW'(full_mask[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = SCAN;
            SCAN:     if (scan_last) state_nx = (mask_scan == '0) ? DONE : FLASH;
            FLASH:    if (flash_end) state_nx = COLLAPSE;
            COLLAPSE: if (collapse_end) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
        if (state == IDLE) begin
            board_out = board_q;
        end else begin
            board_out = work;
            for (int r = 0; r < ROWS; r++) begin
                if ((state == FLASH) && phase && full_mask[r]) board_out[r] = {COLS{FLASH_CODE}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            board_q       <= '0;
            work          <= '0;
            full_mask     <= '0;
            row_ptr       <= '0;
            rd            <= '0;
            wr            <= '0;
            tick_cnt      <= '0;
            phase         <= 1'b0;
            lines_cleared <= '0;
        end else begin
            board_q <= board_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= board_in;
                        full_mask <= '0;
                        row_ptr   <= '0;
                    end
                end
                SCAN: begin
                    full_mask <= mask_scan;
                    row_ptr   <= row_ptr + RW'(1);
                    if (scan_last) begin
                        phase    <= 1'b1;
                        tick_cnt <= '0;
                        if (mask_scan == '0) lines_cleared <= '0;
                    end
                end
                FLASH: begin
                    if (frame_tick) begin
                        phase    <= ~phase;
                        tick_cnt <= tick_cnt + FW'(1);
                    end
                    if (flash_end) begin
                        rd <= BOTTOM;
                        wr <= BOTTOM;
                    end
                end
                COLLAPSE: begin
                    // rd never climbs above wr, so a row is read before anything overwrites it
                    if (!rd[RW]) begin
                        if (!full_mask[rd_idx]) begin
                            work[wr_idx] <= work[rd_idx];
                            wr           <= wr - IDX_ONE;
                        end
                        rd <= rd - IDX_ONE;
                    end else begin
                        work[wr_idx] <= '0;
                        wr           <= wr - IDX_ONE;
                    end
                    if (collapse_end) lines_cleared <= n_full;
                end
                default: ;
            endcase
        end
    end

`ifdef LINE_CLEAR_TOTAL_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_lines} + 17'(lines_cleared);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_lines <= '0;
        end else if (state == DONE) begin
            total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Self-checking bench for line_clear_ctrl: directed cases plus randomized boards,
// compared every cycle against a queue-based model of the row-clear rules.
module tb_line_clear_ctrl;
    import line_clear_pkg::*;

    localparam int ROWS = 12;
    localparam int COLS = 10;
    localparam int FF   = 6;
    localparam int LW   = $clog2(ROWS + 1);

    localparam int P_IDLE  = 0;
    localparam int P_SCAN  = 1;
    localparam int P_FLASH = 2;
    localparam int P_COLL  = 3;
    localparam int P_DONE  = 4;

    typedef logic [ROWS-1:0][0:4*COLS-1] board_t;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b1;
    logic          start      = 1'b0;
    logic          frame_tick = 1'b0;
    board_t        board_in   = '0;
    board_t        board_out;
    logic          busy;
    logic          done;
    logic [LW-1:0] lines_cleared;
`ifdef LINE_CLEAR_TOTAL_EN
    logic [15:0]   total_lines;
`endif

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    line_clear_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .FLASH_FRAMES (FF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .frame_tick    (frame_tick),
        .board_in      (board_in),
        .board_out     (board_out),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
`ifdef LINE_CLEAR_TOTAL_EN
        ,
        .total_lines   (total_lines)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input board_t act, input board_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit row_is_full(input row_t rw);
        for (int j = 0; j < COLS; j++) begin
            if (rw[4*j +: 4] == 4'h0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic board_t flash_view(input board_t b, input logic [ROWS-1:0] m);
        for (int r = 0; r < ROWS; r++) begin
            if (m[r]) b[r] = {COLS{4'hF}};
        end
        return b;
    endfunction

    function automatic board_t rand_board();
        board_t b;
        for (int r = 0; r < ROWS; r++) begin
            bit make_full;
            make_full = ($urandom_range(0, 2) == 0);
            for (int j = 0; j < COLS; j++) begin
                if (make_full || $urandom_range(0, 3) != 0) b[r][4*j +: 4] = 4'($urandom_range(1, 8));
                else                                        b[r][4*j +: 4] = 4'h0;
            end
        end
        return b;
    endfunction

    // reference model: phase, snapshot, survivor queue, flash tick count
    int               m_ph    = P_IDLE;
    int               m_left  = 0;
    int               m_ticks = 0;
    int               m_n     = 0;
    int               m_lines = 0;
    int               m_total = 0;
    board_t           m_snap  = '0;
    board_t           m_comp  = '0;
    board_t           m_prev  = '0;
    logic [ROWS-1:0]  m_full  = '0;
    row_t             kept[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = P_IDLE; m_left = 0; m_ticks = 0; m_n = 0; m_lines = 0; m_total = 0;
            m_snap = '0; m_comp = '0; m_prev = '0; m_full = '0;
        end else begin
            case (m_ph)
                P_IDLE: if (start) begin
                    m_snap = board_in;
                    kept.delete();
                    for (int r = 0; r < ROWS; r++) begin
                        m_full[r] = row_is_full(board_in[r]);
                        if (!m_full[r]) kept.push_back(board_in[r]);
                    end
                    m_n = ROWS - kept.size();
                    for (int r = 0; r < ROWS; r++) m_comp[r] = (r < m_n) ? '0 : kept[r - m_n];
                    m_ph   = P_SCAN;
                    m_left = ROWS;
                end
                P_SCAN: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_n == 0) begin m_ph = P_DONE; m_lines = 0; end
                        else begin m_ph = P_FLASH; m_ticks = 0; end
                    end
                end
                P_FLASH: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == FF) begin m_ph = P_COLL; m_left = ROWS + m_n; end
                end
                P_COLL: begin
                    m_left--;
                    if (m_left == 0) begin m_ph = P_DONE; m_lines = m_n; end
                end
                default: begin
                    m_ph    = P_IDLE;
                    m_total = (m_total + m_lines > 65535) ? 65535 : m_total + m_lines;
                end
            endcase
            m_prev = board_in;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("busy", busy, m_ph != P_IDLE);
            chk("done", done, m_ph == P_DONE);
            if (done === 1'b1) done_cnt++;
            case (m_ph)
                P_IDLE: begin
                    chk_b("idle_board", board_out, m_prev);
                    chk("idle_lines", lines_cleared, m_lines);
                end
                P_SCAN:  chk_b("scan_board", board_out, m_snap);
                P_FLASH: chk_b("flash_board", board_out,
                               (m_ticks % 2 == 0) ? flash_view(m_snap, m_full) : m_snap);
                P_DONE: begin
                    chk_b("done_board", board_out, m_comp);
                    chk("done_lines", lines_cleared, m_lines);
                end
                default: ;
            endcase
`ifdef LINE_CLEAR_TOTAL_EN
            chk("total_lines", total_lines, m_total);
`endif
        end
    end

    task automatic cyc();
        @(negedge clk);
        #2;
    endtask

    // lat: 0 when done lands on cycle 13 (no full rows), else cycles from the last tick to done
    task automatic run_op(input board_t b, input bit tick_at_start, input bit repulse,
                          output int lat, output board_t fin, output board_t fl,
                          output logic [LW-1:0] nl);
        int d0;
        d0 = done_cnt;
        fl = '0;
        board_in = b; start = 1'b1; frame_tick = tick_at_start;
        cyc();
        start = 1'b0; frame_tick = 1'b0;
        for (int i = 0; i < ROWS - 1; i++) begin
            start = repulse && (i == 4);
            cyc();
        end
        start = 1'b0;
        cyc();
        if (done === 1'b1) begin
            lat = 0;
        end else begin
            fl = board_out;
            for (int t = 1; t < FF; t++) begin
                frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
                start = repulse && (t == 2); cyc(); start = 1'b0;
            end
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
            lat = 1;
            while (done !== 1'b1 && lat < 200) begin cyc(); lat++; end
            if (done !== 1'b1) chk("done_timeout", done, 1);
        end
        fin = board_out;
        nl  = lines_cleared;
        cyc();
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got time %0t expected below 1000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        board_t           b, fin, fl, exp;
        int               lat, guard;
        logic [LW-1:0]    nl;
`ifdef LINE_CLEAR_TOTAL_EN
        logic [15:0]      tot0;
`endif

        #1 rst_n = 1'b0;
        #1;
        chk_b("reset_board", board_out, '0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_lines", lines_cleared, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        cyc(); cyc();

        // empty board
        b = '0;
        run_op(b, 1'b0, 1'b0, lat, fin, fl, nl);
        chk("A_latency", lat, 0);
        chk_b("A_final", fin, b);
        chk("A_lines", nl, 0);

        // bottom row full, one block above it
        b = '0; b[11] = 40'h1111111111; b[10] = 40'h2000000000;
        run_op(b, 1'b0, 1'b0, lat, fin, fl, nl);
        chk("B_flash_row11", fl[11], 40'hFFFFFFFFFF);
        chk("B_flash_row10", fl[10], 40'h2000000000);
        chk("B_collapse", lat, 14);
        exp = '0; exp[11] = 40'h2000000000;
        chk_b("B_final", fin, exp);
        chk("B_lines", nl, 1);

        // two separated full rows; start coincides with a frame tick
        b = '0; b[11] = 40'h8765432187; b[10] = 40'h0007000000;
        b[9] = 40'h1234567812; b[8] = 40'h5000000000;
        run_op(b, 1'b1, 1'b0, lat, fin, fl, nl);
        chk("C_collapse", lat, 15);
        exp = '0; exp[11] = 40'h0007000000; exp[10] = 40'h5000000000;
        chk_b("C_final", fin, exp);
        chk("C_lines", nl, 2);

        // every row full; start re-pulsed during scan and flash
        for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < COLS; j++) b[r][4*j +: 4] = 4'(((r + j) % 8) + 1);
`ifdef LINE_CLEAR_TOTAL_EN
        tot0 = total_lines;
`endif
        run_op(b, 1'b0, 1'b1, lat, fin, fl, nl);
        chk("D_collapse", lat, 25);
        chk_b("D_final", fin, '0);
        chk("D_lines", nl, 12);
`ifdef LINE_CLEAR_TOTAL_EN
        chk("D_total_step", total_lines - tot0, 12);
`endif

        // reset in the middle of the flash phase
        b = '0; b[11] = 40'h1111111111; b[10] = 40'h2000000000;
        board_in = b; start = 1'b1; cyc(); start = 1'b0;
        repeat (ROWS) cyc();
        for (int t = 0; t < 3; t++) begin
            frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
        end
        rst_n = 1'b0;
        #1;
        chk_b("E_reset_board", board_out, '0);
        chk("E_reset_busy", busy, 0);
        cyc();
        rst_n = 1'b1; board_in = '0;
        cyc();
        run_op('0, 1'b0, 1'b0, lat, fin, fl, nl);
        chk("E_latency", lat, 0);
        chk("E_lines", nl, 0);

        // randomized boards, ticks, spurious starts and board_in churn while busy
        for (int k = 0; k < 40; k++) begin
            board_in = rand_board(); start = 1'b1; frame_tick = 1'($urandom_range(0, 1));
            cyc();
            start = 1'b0;
            guard = 0;
            while (done !== 1'b1 && guard < 400) begin
                frame_tick = ($urandom_range(0, 2) == 0);
                start      = ($urandom_range(0, 7) == 0);
                board_in   = rand_board();
                cyc();
                guard++;
            end
            if (done !== 1'b1) chk("rand_done_timeout", done, 1);
            start = 1'b0; frame_tick = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                board_in = rand_board(); frame_tick = 1'($urandom_range(0, 1));
                cyc();
            end
            frame_tick = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
Sequencer for completed-row handling on the 12x10 playfield that feeds the board-to-colour conversion stage. On `start` (after a piece locks) it snapshots the board and scans for full rows. It flashes those rows with the flash colour code for a programmable number of display frames, then collapses the board downward. It drives the board the colour stage sees and returns the compacted board plus a cleared-line count to game logic.

Parameters:
ROWS, 12, playfield rows; row 0 = top, row ROWS-1 = bottom
COLS, 10, cells per row; 4-bit code per cell
FLASH_FRAMES, 6, frame_tick pulses spent in the flash phase (min 1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request: scan board_in for full rows
frame_tick  input  1  one-cycle pulse per display frame
board_in  input  ROWS x 4*COLS  live board from game logic; cell j at bits [4j +: 4], MSB-first indexing
board_out  output  ROWS x 4*COLS  board to the colour-conversion stage, same layout
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; board_out holds the compacted board
lines_cleared  output  $clog2(ROWS+1)  count of removed rows; valid from done, held until next start

Behaviour:
- Reset (async, rst_n=0): state IDLE. board_out, work board, full_mask, lines_cleared, counters all 0. busy=0, done=0.
- IDLE: board_out <= board_in every cycle (1-cycle latency). On start=1: work <= board_in, full_mask <= 0, row ptr <= 0, go SCAN.
- SCAN: one row per cycle, rows 0..ROWS-1 (ROWS cycles).
  - A row is full iff all COLS cells != 4'h0.
  - Set full_mask[r] for each full row.
  - After row ROWS-1: if full_mask==0, go DONE; else go FLASH with phase=1 and tick_cnt=0.
  - board_out = work.
- FLASH:
  - board_out = work, except masked rows show all cells = FLASH_CODE (4'hF) while phase=1.
  - Each frame_tick: phase toggles and tick_cnt increments.
  - On the tick that makes tick_cnt==FLASH_FRAMES: go COLLAPSE with rd=wr=ROWS-1.
  - frame_tick is ignored in all other states.
- COLLAPSE: in-place bottom-up compaction of work.
  - Read pass, while rd>=0: if full_mask[rd], rd--. Otherwise work[wr] <= work[rd]; wr--, rd--.
  - Zero-fill pass, after rd passes 0: work[wr] <= 0, wr-- each cycle until wr<0.
  - Duration is exactly ROWS + N cycles, where N = popcount(full_mask).
  - Then go DONE. board_out = work (unmasked) throughout.
- DONE (1 cycle): done=1, lines_cleared=N, board_out=work, next state IDLE. Game logic loads board_out on done.
- start while busy=1: ignored, no queueing.
- board_in while busy: ignored.
- start and frame_tick in the same IDLE cycle: start accepted, tick dropped.
- rst_n deasserted mid-operation: immediate return to reset values; the partial board is discarded.
- Latency from start to done: ROWS+1 cycles with no full rows; otherwise ROWS + flash time + ROWS+N + 1.

Optional Feature:
LINE_CLEAR_TOTAL_EN
- Defined: adds output total_lines[15:0]. It is reset to 0 and increases by lines_cleared on each done, saturating at 16'hFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package line_clear_pkg holds:
  - cell codes EMPTY_CODE=4'h0, T/SQUARE/J/L/Z/S/LINE/CURSED = 4'h1..4'h8, FLASH_CODE=4'hF
  - default ROWS/COLS
  - state enum {IDLE, SCAN, FLASH, COLLAPSE, DONE}
  - row typedef logic [0:4*COLS-1]
- Sub-module row_full_detect (combinational, one row in, full flag out), instantiated once on the SCAN row mux.

Test Plan:
- Empty board, start -> busy for 12 cycles of SCAN; done 13 cycles after start; lines_cleared=0; board_out == input board.
- Row 11 all 4'h1, row 10 cell0=4'h2, rest 0, FLASH_FRAMES=6 -> row 11 of board_out reads all 4'hF first cycle of FLASH and alternates on ticks. After 6 ticks, 13 COLLAPSE cycles. Final row 11 = {4'h2, 0...}, rows 0..10 = 0, lines_cleared=1.
- Rows 9 and 11 full, row 10 = cell3 4'h7, row 8 = cell0 4'h5 -> final row 11 = old row 10, row 10 = old row 8, rows 0..9 = 0, lines_cleared=2, COLLAPSE = 14 cycles.
- All 12 rows full (mixed codes 1..8) -> final board all zero, lines_cleared=12. With LINE_CLEAR_TOTAL_EN, total_lines steps 0->12.
- rst_n pulsed low after 3 frame_ticks in FLASH -> board_out=0, busy=0 at once. A following start with an empty board completes normally with lines_cleared=0.
- start re-pulsed during SCAN and FLASH -> no restart, done once. start coincident with frame_tick in IDLE -> accepted, flash count unaffected.
